// File: rtl/ps2_pkg.sv
// Shared types and constants for the PS/2 keyboard receiver.
// Optional make-only filtering is selected with PS2_BREAK_FILTER_EN (see ps2_rx).
package ps2_pkg;

  typedef enum logic [1:0] {
    IDLE,
    DATA,
    PARITY,
    STOP
  } ps2_state_t;

  localparam int         PS2_DATA_BITS = 8;
  localparam logic [7:0] PS2_BREAK     = 8'hF0;
  localparam logic [7:0] PS2_EXT       = 8'hE0;

  // Odd parity: the data bits plus the parity bit must hold an odd number of ones.
  function automatic logic odd_parity_ok(input logic [7:0] data, input logic par);
    return ^{data, par};
  endfunction

endpackage

// File: rtl/ps2_sync_edge.sv
// Two-flop synchroniser for an idle-high asynchronous line, plus a detector
// that flags the cycle on which the synchronised line drops from 1 to 0.
module ps2_sync_edge
  import ps2_pkg::*;
(
  input  logic clk,
  input  logic rst,
  input  logic din,
  output logic sync,
  output logic fall
);

  logic meta;
  logic prev;

  always_ff @(posedge clk) begin
    if (rst) begin
      meta <= 1'b1;
      sync <= 1'b1;
      prev <= 1'b1;
    end else begin
      meta <= din;
      sync <= meta;
      prev <= sync;
    end
  end

  assign fall = prev & ~sync;

endmodule

// File: rtl/ps2_rx.sv
// PS/2 device-to-host frame receiver: start, 8 data bits LSB first, odd parity, stop.
// Define PS2_BREAK_FILTER_EN to emit make codes only (break and extended prefixes dropped).
module ps2_rx
  import ps2_pkg::*;
#(
  parameter int TIMEOUT_CYCLES = 50000
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       ps2_clk,
  input  logic       ps2_data,
  output logic [7:0] code,
  output logic       code_valid,
  output logic       parity_err,
  output logic       frame_err
);

  localparam int TW = $clog2(TIMEOUT_CYCLES + 1);
  localparam int CW = $clog2(PS2_DATA_BITS);
  localparam logic [TW-1:0] TLIMIT   = TW'(TIMEOUT_CYCLES - 1);
  localparam logic [CW-1:0] LAST_BIT = CW'(PS2_DATA_BITS - 1);

  logic          clk_sync;
  logic          clk_fall;
  logic          data_meta;
  logic          data_sync;
  ps2_state_t    state;
  logic [CW-1:0] bit_cnt;
  logic [TW-1:0] tcnt;
  logic [7:0]    shift;
  logic          par_bit;
  logic          parity_ok;
`ifdef PS2_BREAK_FILTER_EN
  logic          break_pending;
`endif

  ps2_sync_edge u_clk_sync (
    .clk  (clk),
    .rst  (rst),
    .din  (ps2_clk),
    .sync (clk_sync),
    .fall (clk_fall)
  );

  // The data line only needs synchronising; its delay matches the clock path.
  always_ff @(posedge clk) begin
    if (rst) begin
      data_meta <= 1'b1;
      data_sync <= 1'b1;
    end else begin
      data_meta <= ps2_data;
      data_sync <= data_meta;
    end
  end

  assign parity_ok = odd_parity_ok(shift, par_bit);

  always_ff @(posedge clk) begin
    if (rst) begin
      state      <= IDLE;
      bit_cnt    <= '0;
      tcnt       <= '0;
      shift      <= '0;
      par_bit    <= 1'b0;
      code       <= 8'h00;
      code_valid <= 1'b0;
      parity_err <= 1'b0;
      frame_err  <= 1'b0;
`ifdef PS2_BREAK_FILTER_EN
      break_pending <= 1'b0;
`endif
    end else begin
      code_valid <= 1'b0;
      parity_err <= 1'b0;
      frame_err  <= 1'b0;
      // A sampling event takes priority over a timeout landing on the same cycle.
      if (clk_fall) begin
        tcnt <= '0;
        case (state)
          IDLE: begin
            if (!data_sync) begin
              state   <= DATA;
              bit_cnt <= '0;
            end
          end
          DATA: begin
            shift   <= {data_sync, shift[7:1]};
            bit_cnt <= bit_cnt + CW'(1);
            if (bit_cnt == LAST_BIT) state <= PARITY;
          end
          PARITY: begin
            par_bit <= data_sync;
            state   <= STOP;
          end
          STOP: begin
            state <= IDLE;
            if (!parity_ok) parity_err <= 1'b1;
            if (!data_sync) frame_err  <= 1'b1;
            if (parity_ok && data_sync) begin
`ifdef PS2_BREAK_FILTER_EN
              if (break_pending) begin
                break_pending <= 1'b0;
              end else if (shift == PS2_BREAK) begin
                break_pending <= 1'b1;
              end else if (shift != PS2_EXT) begin
                code       <= shift;
                code_valid <= 1'b1;
              end
`else
              code       <= shift;
              code_valid <= 1'b1;
`endif
            end
`ifdef PS2_BREAK_FILTER_EN
            else begin
              break_pending <= 1'b0;
            end
`endif
          end
          default: state <= IDLE;
        endcase
      end else if (state == IDLE) begin
        tcnt <= '0;
      end else if (tcnt == TLIMIT) begin
        state     <= IDLE;
        tcnt      <= '0;
        frame_err <= 1'b1;
`ifdef PS2_BREAK_FILTER_EN
        break_pending <= 1'b0;
`endif
      end else begin
        tcnt <= tcnt + TW'(1);
      end
    end
  end

endmodule

// File: tb/tb_ps2_rx.sv
// Directed self-checking bench for ps2_rx (TIMEOUT_CYCLES=200, ps2_clk half-period 40 clk).
// Honours PS2_BREAK_FILTER_EN when it is defined for the build.
module tb_ps2_rx;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       ps2_clk = 1'b1;
  logic       ps2_data = 1'b1;
  logic [7:0] code;
  logic       code_valid;
  logic       parity_err;
  logic       frame_err;

  int checks = 0;
  int failures = 0;

  int cv_cnt = 0;
  int pe_cnt = 0;
  int fe_cnt = 0;
  int wide_cnt = 0;
  logic cv_prev = 1'b0;
  logic pe_prev = 1'b0;
  logic fe_prev = 1'b0;
  logic [7:0] codes[$];

  ps2_rx #(.TIMEOUT_CYCLES(200)) dut (
    .clk        (clk),
    .rst        (rst),
    .ps2_clk    (ps2_clk),
    .ps2_data   (ps2_data),
    .code       (code),
    .code_valid (code_valid),
    .parity_err (parity_err),
    .frame_err  (frame_err)
  );

  always #5 clk = ~clk;

  // Pulse monitor: counts strobes, records emitted codes and any strobe wider than 1 clk.
  always @(negedge clk) begin
    if (code_valid) begin
      cv_cnt++;
      codes.push_back(code);
      if (cv_prev) wide_cnt++;
    end
    if (parity_err) begin
      pe_cnt++;
      if (pe_prev) wide_cnt++;
    end
    if (frame_err) begin
      fe_cnt++;
      if (fe_prev) wide_cnt++;
    end
    cv_prev = code_valid;
    pe_prev = parity_err;
    fe_prev = frame_err;
  end

  task automatic ps2_bit(input logic b);
    ps2_data = b;
    repeat (40) @(negedge clk);
    ps2_clk = 1'b0;
    repeat (40) @(negedge clk);
    ps2_clk = 1'b1;
  endtask

  task automatic send_frame(input logic [7:0] d, input logic p, input logic s);
    ps2_bit(1'b0);
    for (int i = 0; i < 8; i++) ps2_bit(d[i]);
    ps2_bit(p);
    ps2_bit(s);
    ps2_data = 1'b1;
    repeat (40) @(negedge clk);
  endtask

  task automatic test_reset();
    rst = 1'b1;
    ps2_clk = 1'b1;
    ps2_data = 1'b1;
    repeat (5) @(negedge clk);
    checks++; if (code !== 8'h00) begin failures++; $display("[TB] FAIL reset_code: got %h expected 00", code); end
    checks++; if (code_valid !== 1'b0) begin failures++; $display("[TB] FAIL reset_code_valid: got %b expected 0", code_valid); end
    checks++; if (parity_err !== 1'b0) begin failures++; $display("[TB] FAIL reset_parity_err: got %b expected 0", parity_err); end
    checks++; if (frame_err !== 1'b0) begin failures++; $display("[TB] FAIL reset_frame_err: got %b expected 0", frame_err); end
    rst = 1'b0;
    repeat (10) @(negedge clk);
  endtask

  task automatic test_good_frame();
    int cv0, pe0, fe0;
    cv0 = cv_cnt; pe0 = pe_cnt; fe0 = fe_cnt;
    send_frame(8'h45, 1'b0, 1'b1);
    checks++; if (code !== 8'h45) begin failures++; $display("[TB] FAIL good_code: got %h expected 45", code); end
    checks++; if (cv_cnt - cv0 !== 1) begin failures++; $display("[TB] FAIL good_valid_count: got %0d expected 1", cv_cnt - cv0); end
    checks++; if (codes.size() == 0 || codes[$] !== 8'h45) begin failures++; $display("[TB] FAIL good_strobe_code: got %0d entries expected last 45", codes.size()); end
    checks++; if (pe_cnt - pe0 !== 0) begin failures++; $display("[TB] FAIL good_parity_flag: got %0d expected 0", pe_cnt - pe0); end
    checks++; if (fe_cnt - fe0 !== 0) begin failures++; $display("[TB] FAIL good_frame_flag: got %0d expected 0", fe_cnt - fe0); end
  endtask

  task automatic test_parity_error();
    int cv0, pe0, fe0;
    cv0 = cv_cnt; pe0 = pe_cnt; fe0 = fe_cnt;
    send_frame(8'h16, 1'b1, 1'b1);
    checks++; if (pe_cnt - pe0 !== 1) begin failures++; $display("[TB] FAIL parity_flag: got %0d expected 1", pe_cnt - pe0); end
    checks++; if (fe_cnt - fe0 !== 0) begin failures++; $display("[TB] FAIL parity_frame_flag: got %0d expected 0", fe_cnt - fe0); end
    checks++; if (cv_cnt - cv0 !== 0) begin failures++; $display("[TB] FAIL parity_valid_count: got %0d expected 0", cv_cnt - cv0); end
    checks++; if (code !== 8'h45) begin failures++; $display("[TB] FAIL parity_code_held: got %h expected 45", code); end
  endtask

  task automatic test_frame_error();
    int cv0, pe0, fe0;
    cv0 = cv_cnt; pe0 = pe_cnt; fe0 = fe_cnt;
    send_frame(8'h1E, 1'b1, 1'b0);
    checks++; if (fe_cnt - fe0 !== 1) begin failures++; $display("[TB] FAIL stop_frame_flag: got %0d expected 1", fe_cnt - fe0); end
    checks++; if (pe_cnt - pe0 !== 0) begin failures++; $display("[TB] FAIL stop_parity_flag: got %0d expected 0", pe_cnt - pe0); end
    checks++; if (cv_cnt - cv0 !== 0) begin failures++; $display("[TB] FAIL stop_valid_count: got %0d expected 0", cv_cnt - cv0); end
    checks++; if (code !== 8'h45) begin failures++; $display("[TB] FAIL stop_code_held: got %h expected 45", code); end
  endtask

  task automatic test_timeout();
    int cv0, pe0, fe0, hit;
    cv0 = cv_cnt; pe0 = pe_cnt; fe0 = fe_cnt;
    hit = 0;
    ps2_bit(1'b0);
    ps2_bit(1'b1);
    ps2_bit(1'b0);
    ps2_bit(1'b1);
    ps2_data = 1'b0;
    repeat (40) @(negedge clk);
    ps2_clk = 1'b0;
    // Pin edge -> event is 3 clk, then 200 idle clk until the counter hits 199.
    for (int i = 1; i <= 300; i++) begin
      @(negedge clk);
      if (i == 40) begin
        ps2_clk = 1'b1;
        ps2_data = 1'b1;
      end
      if (frame_err === 1'b1 && hit == 0) hit = i;
    end
    checks++; if (hit < 200 || hit > 206) begin failures++; $display("[TB] FAIL timeout_latency: got %0d expected 200..206", hit); end
    checks++; if (fe_cnt - fe0 !== 1) begin failures++; $display("[TB] FAIL timeout_flag_count: got %0d expected 1", fe_cnt - fe0); end
    checks++; if (cv_cnt - cv0 !== 0) begin failures++; $display("[TB] FAIL timeout_valid_count: got %0d expected 0", cv_cnt - cv0); end
    checks++; if (pe_cnt - pe0 !== 0) begin failures++; $display("[TB] FAIL timeout_parity_flag: got %0d expected 0", pe_cnt - pe0); end
    send_frame(8'h25, 1'b0, 1'b1);
    checks++; if (code !== 8'h25) begin failures++; $display("[TB] FAIL after_timeout_code: got %h expected 25", code); end
    checks++; if (cv_cnt - cv0 !== 1) begin failures++; $display("[TB] FAIL after_timeout_valid: got %0d expected 1", cv_cnt - cv0); end
  endtask

  task automatic test_back_to_back();
    int cv0, q0;
    cv0 = cv_cnt; q0 = codes.size();
    send_frame(8'hF0, 1'b1, 1'b1);
    send_frame(8'h1C, 1'b0, 1'b1);
    send_frame(8'h1C, 1'b0, 1'b1);
`ifdef PS2_BREAK_FILTER_EN
    checks++; if (cv_cnt - cv0 !== 1) begin failures++; $display("[TB] FAIL break_valid_count: got %0d expected 1", cv_cnt - cv0); end
    checks++; if (codes.size() != q0 + 1 || codes[q0] !== 8'h1C) begin failures++; $display("[TB] FAIL break_code: got %0d entries expected one 1C", codes.size() - q0); end
`else
    checks++; if (cv_cnt - cv0 !== 3) begin failures++; $display("[TB] FAIL raw_valid_count: got %0d expected 3", cv_cnt - cv0); end
    checks++; if (codes.size() != q0 + 3 || codes[q0] !== 8'hF0) begin failures++; $display("[TB] FAIL raw_code0: got %0d entries expected F0 first", codes.size() - q0); end
    checks++; if (codes.size() != q0 + 3 || codes[q0+1] !== 8'h1C) begin failures++; $display("[TB] FAIL raw_code1: expected 1C second"); end
    checks++; if (codes.size() != q0 + 3 || codes[q0+2] !== 8'h1C) begin failures++; $display("[TB] FAIL raw_code2: expected 1C third"); end
`endif
    checks++; if (code !== 8'h1C) begin failures++; $display("[TB] FAIL b2b_final_code: got %h expected 1C", code); end
  endtask

  task automatic test_reset_mid_frame();
    int cv0, pe0, fe0;
    ps2_bit(1'b0);
    ps2_bit(1'b1);
    ps2_bit(1'b0);
    ps2_bit(1'b1);
    ps2_bit(1'b1);
    ps2_data = 1'b1;
    repeat (40) @(negedge clk);
    ps2_clk = 1'b0;
    repeat (5) @(negedge clk);
    cv0 = cv_cnt; pe0 = pe_cnt; fe0 = fe_cnt;
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    checks++; if (code !== 8'h00) begin failures++; $display("[TB] FAIL midrst_code: got %h expected 00", code); end
    checks++; if (code_valid !== 1'b0) begin failures++; $display("[TB] FAIL midrst_code_valid: got %b expected 0", code_valid); end
    checks++; if (parity_err !== 1'b0) begin failures++; $display("[TB] FAIL midrst_parity_err: got %b expected 0", parity_err); end
    checks++; if (frame_err !== 1'b0) begin failures++; $display("[TB] FAIL midrst_frame_err: got %b expected 0", frame_err); end
    repeat (35) @(negedge clk);
    ps2_clk = 1'b1;
    repeat (300) @(negedge clk);
    send_frame(8'h25, 1'b0, 1'b1);
    checks++; if (code !== 8'h25) begin failures++; $display("[TB] FAIL midrst_next_code: got %h expected 25", code); end
    checks++; if (cv_cnt - cv0 !== 1) begin failures++; $display("[TB] FAIL midrst_valid_count: got %0d expected 1", cv_cnt - cv0); end
    checks++; if ((pe_cnt - pe0) + (fe_cnt - fe0) !== 0) begin failures++; $display("[TB] FAIL midrst_flags: got %0d expected 0", (pe_cnt - pe0) + (fe_cnt - fe0)); end
  endtask

  initial begin
    test_reset();
    test_good_frame();
    test_parity_error();
    test_frame_error();
    test_timeout();
    test_back_to_back();
    test_reset_mid_frame();
    checks++; if (wide_cnt !== 0) begin failures++; $display("[TB] FAIL pulse_width: got %0d wide strobes expected 0", wide_cnt); end
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
